// File: rtl/game_ctrl.sv
// game_ctrl: play-state controller for the street-crossing game.
// Consumes the comparator's sticky crushed / level_up / endgame flags, tracks
// lives and level, and sequences comparator reset and mover respawn on frame
// boundaries.
// Optional feature: define GAME_TIMER_EN to enable the per-level frame timer
// (timer expiry costs a life exactly like a crush). Without it timer_left is 0.
// state_dbg exposes the FSM state for checkers.
module game_ctrl #(
    parameter int LIVES        = 3,
    parameter int DEAD_FRAMES  = 30,
    parameter int LEVEL_FRAMES = 1800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        crushed,
    input  logic        level_up,
    input  logic        endgame,
    output logic        cmp_resetn,
    output logic        respawn,
    output logic        playing,
    output logic        game_over,
    output logic        game_won,
    output logic [1:0]  lives,
    output logic        level,
    output logic [10:0] timer_left,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] DEAD_INIT  = 8'(DEAD_FRAMES);

    // Reject out-of-range parameters at elaboration.
    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("game_ctrl: LIVES must be 1..3");
    end
    if (DEAD_FRAMES < 1 || DEAD_FRAMES > 255) begin : g_bad_dead
        $error("game_ctrl: DEAD_FRAMES must be 1..255");
    end
    if (LEVEL_FRAMES < 1 || LEVEL_FRAMES > 2047) begin : g_bad_level
        $error("game_ctrl: LEVEL_FRAMES must be 1..2047");
    end

    state_t      state, state_n;
    logic [1:0]  lives_n;
    logic        level_n;
    logic [7:0]  dead_cnt, dead_n;
    logic        lu_q, lu_n;
    logic        timer_expire;
    logic        timer_load;
    logic        lu_edge;

    assign state_dbg = state;
    assign lu_edge   = level_up && !lu_q;

`ifdef GAME_TIMER_EN
    localparam logic [10:0] TIMER_INIT = 11'(LEVEL_FRAMES);
    // A tick that takes the level timer from 1 to 0 counts as a crush.
    assign timer_expire = (state == S_PLAY) && frame_tick && (timer_left == 11'd1);
`else
    assign timer_expire = 1'b0;
`endif

    // Next-state, lives, level, death counter and level_up edge register.
    always_comb begin
        state_n    = state;
        lives_n    = lives;
        level_n    = level;
        dead_n     = dead_cnt;
        lu_n       = lu_q;
        timer_load = 1'b0;
        case (state)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) begin
                    state_n = S_CLEAR;
                    lives_n = LIVES_INIT;
                    level_n = 1'b0;
                end
            end
            S_CLEAR: begin
                state_n    = S_PLAY;
                lu_n       = 1'b0;
                timer_load = 1'b1;
            end
            S_PLAY: begin
                lu_n = level_up;
                if (crushed || timer_expire) begin
                    if (lives == 2'd1) begin
                        state_n = S_OVER;
                        lives_n = 2'd0;
                    end else begin
                        state_n = S_DYING;
                        lives_n = lives - 2'd1;
                        dead_n  = DEAD_INIT;
                    end
                end else if (endgame) begin
                    state_n = S_WIN;
                end else if (lu_edge) begin
                    level_n    = 1'b1;
                    timer_load = 1'b1;
                end
            end
            S_DYING: begin
                // The comparator's crushed stays high here until CLEAR resets it.
                if (frame_tick) begin
                    dead_n = dead_cnt - 8'd1;
                    if (dead_cnt == 8'd1) begin
                        // A death always drops the player back to level 1.
                        state_n = S_CLEAR;
                        level_n = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            lives      <= LIVES_INIT;
            level      <= 1'b0;
            dead_cnt   <= 8'd0;
            lu_q       <= 1'b0;
            cmp_resetn <= 1'b0;
            respawn    <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
        end else begin
            state      <= state_n;
            lives      <= lives_n;
            level      <= level_n;
            dead_cnt   <= dead_n;
            lu_q       <= lu_n;
            cmp_resetn <= (state_n == S_PLAY) || (state_n == S_DYING);
            respawn    <= (state_n == S_CLEAR);
            playing    <= (state_n == S_PLAY);
            game_over  <= (state_n == S_OVER);
            game_won   <= (state_n == S_WIN);
        end
    end

`ifdef GAME_TIMER_EN
    // Level timer: reload on CLEAR and accepted level-up, count frames in PLAY,
    // hold everywhere else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_left <= 11'd0;
        end else if (timer_load) begin
            timer_left <= TIMER_INIT;
        end else if (state == S_PLAY && frame_tick && timer_left != 11'd0) begin
            timer_left <= timer_left - 11'd1;
        end
    end
`else
    assign timer_left = 11'd0;
    logic unused_timer_load;
    assign unused_timer_load = timer_load;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: table-driven directed bench for game_ctrl (default parameters,
// LEVEL_FRAMES=5 so the timed build finishes quickly).
module tb_game_ctrl;

    localparam int DEAD = 30;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic        crushed = 1'b0;
    logic        level_up = 1'b0;
    logic        endgame = 1'b0;
    logic        cmp_resetn, respawn, playing, game_over, game_won, level;
    logic [1:0]  lives;
    logic [10:0] timer_left;
    logic [2:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    game_ctrl #(.LIVES(3), .DEAD_FRAMES(DEAD), .LEVEL_FRAMES(5)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .crushed(crushed), .level_up(level_up), .endgame(endgame),
        .cmp_resetn(cmp_resetn), .respawn(respawn), .playing(playing),
        .game_over(game_over), .game_won(game_won), .lives(lives),
        .level(level), .timer_left(timer_left), .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clock = ~clock;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       st, ft, cr, lu, eg;
        logic       wait_dead;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected output word: {cmp_resetn, respawn, playing, game_over, game_won, lives, level}.
    function automatic logic [7:0] outs(input logic c, r, p, o, w,
                                        input logic [1:0] l, input logic lv);
        return {c, r, p, o, w, l, lv};
    endfunction
    function automatic logic [7:0] e_idle();           return outs(0,0,0,0,0,2'd3,0); endfunction
    function automatic logic [7:0] e_clr(input logic [1:0] l); return outs(0,1,0,0,0,l,0); endfunction
    function automatic logic [7:0] e_play(input logic [1:0] l, input logic lv); return outs(1,0,1,0,0,l,lv); endfunction
    function automatic logic [7:0] e_dying(input logic [1:0] l, input logic lv); return outs(1,0,0,0,0,l,lv); endfunction
    function automatic logic [7:0] e_over();           return outs(0,0,0,1,0,2'd0,0); endfunction
    function automatic logic [7:0] e_win(input logic [1:0] l, input logic lv); return outs(0,0,0,0,1,l,lv); endfunction

    function automatic void add(input logic st, ft, cr, lu, eg, input logic [7:0] exp,
                                input logic wd = 1'b0);
        vec_t v;
        v.st = st; v.ft = ft; v.cr = cr; v.lu = lu; v.eg = eg;
        v.wait_dead = wd; v.exp = exp;
        tbl.push_back(v);
    endfunction

    function automatic logic [7:0] got();
        return {cmp_resetn, respawn, playing, game_over, game_won, lives, level};
    endfunction

    task automatic check8(input string name, input logic [7:0] g, input logic [7:0] e);
        n_cmp++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (cmp_resetn,respawn,playing,over,won,lives,level)",
                     name, g, e);
        end
    endtask

    task automatic check11(input string name, input logic [10:0] g, input logic [10:0] e);
        n_cmp++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, g, e);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply(input string name, input logic st, ft, cr, lu, eg,
                         input logic [7:0] exp);
        @(negedge clock);
        start = st; frame_tick = ft; crushed = cr; level_up = lu; endgame = eg;
        @(posedge clock);
        #1;
        check8(name, got(), exp);
    endtask

    // Sit in DYING for exactly DEAD frame ticks with idle cycles between them.
    task automatic die_wait(input int idx, input logic [7:0] dying_exp);
        string nm;
        for (int k = 1; k < DEAD; k++) begin
            nm = $sformatf("vec%0d_dying_gap%0d", idx, k);
            apply(nm, 0, 0, 0, 0, 0, dying_exp);
            nm = $sformatf("vec%0d_dying_tick%0d", idx, k);
            apply(nm, 0, 1, 0, 0, 0, dying_exp);
        end
        nm = $sformatf("vec%0d_respawn", idx);
        apply(nm, 0, 1, 0, 0, 0, e_clr(dying_exp[2:1]));
    endtask

    initial begin
        //           st ft cr lu eg  expected
        add(0,0,0,0,0, e_idle());            // idle stays idle
        add(1,0,0,0,0, e_clr(2'd3));         // start -> CLEAR
        add(0,0,0,0,0, e_play(2'd3,0));      // -> PLAY
        add(0,1,0,0,0, e_play(2'd3,0));      // tick in PLAY, no timeout
        add(1,0,0,0,0, e_play(2'd3,0));      // start ignored in PLAY
        add(0,0,0,1,0, e_play(2'd3,1));      // level_up edge
        add(0,0,0,1,0, e_play(2'd3,1));      // level_up held
        add(0,0,1,1,1, e_dying(2'd2,1));     // crushed beats endgame
        add(0,0,1,1,1, e_dying(2'd2,1));     // crushed ignored in DYING
        add(1,0,0,0,0, e_dying(2'd2,1));     // start ignored in DYING
        add(0,0,0,0,0, e_dying(2'd2,1), 1'b1); // 30 ticks -> CLEAR, level 0
        add(0,0,0,0,0, e_play(2'd2,0));
        add(0,0,1,1,0, e_dying(2'd1,0));     // crush + level_up edge: no level change
        add(0,0,0,0,0, e_dying(2'd1,0), 1'b1);
        add(0,0,0,0,0, e_play(2'd1,0));
        add(0,0,1,0,0, e_over());            // last life
        add(0,1,0,0,0, e_over());
        add(0,0,0,1,0, e_over());
        add(1,0,0,0,0, e_clr(2'd3));         // restart
        add(0,0,0,0,0, e_play(2'd3,0));
        add(0,0,0,0,1, e_win(2'd3,0));       // endgame
        add(0,1,0,0,0, e_win(2'd3,0));
        add(1,0,0,0,0, e_clr(2'd3));
        add(0,0,0,0,0, e_play(2'd3,0));
        add(0,0,0,1,0, e_play(2'd3,1));
        add(0,0,0,1,1, e_win(2'd3,1));       // endgame on level 2
        add(1,0,0,0,0, e_clr(2'd3));         // restart returns to level 1
        add(0,0,0,0,0, e_play(2'd3,0));
        add(0,0,1,0,0, e_dying(2'd2,0));
        add(0,1,0,0,0, e_dying(2'd2,0));

        // Reset values.
        reset = 1'b1;
        #12;
        check8("reset_outputs", got(), e_idle());
        check11("reset_timer", timer_left, 11'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wait_dead)
                die_wait(i, tbl[i].exp);
            else
                apply($sformatf("vec%0d", i), tbl[i].st, tbl[i].ft, tbl[i].cr,
                      tbl[i].lu, tbl[i].eg, tbl[i].exp);
        end

        // Asynchronous reset while DYING takes effect without a clock edge.
        #3;
        reset = 1'b1;
        #1;
        check8("async_reset_dying", got(), e_idle());
        check11("async_reset_timer", timer_left, 11'd0);
        @(negedge clock);
        reset = 1'b0;
        apply("after_reset_idle", 0, 0, 0, 0, 0, e_idle());

`ifdef GAME_TIMER_EN
        // Level timer of 5 frames expires into DYING.
        apply("tmr_start", 1, 0, 0, 0, 0, e_clr(2'd3));
        apply("tmr_play", 0, 0, 0, 0, 0, e_play(2'd3,0));
        check11("tmr_load", timer_left, 11'd5);
        for (int k = 4; k >= 1; k--) begin
            apply($sformatf("tmr_tick_to%0d", k), 0, 1, 0, 0, 0, e_play(2'd3,0));
            check11($sformatf("tmr_val%0d", k), timer_left, 11'(k));
        end
        apply("tmr_expire", 0, 1, 0, 0, 0, e_dying(2'd2,0));
        check11("tmr_expired", timer_left, 11'd0);
        apply("tmr_hold", 0, 1, 0, 0, 0, e_dying(2'd2,0));
        check11("tmr_hold_val", timer_left, 11'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level play-state controller for the street-crossing game. It sits directly downstream of the collision/level comparator: it consumes the comparator's sticky `crushed`, `level_up` and `endgame` flags and tracks lives and level. It drives the comparator's active-low reset (`cmp_resetn`) and a one-cycle `respawn` pulse to the human/vehicle movers. All sequencing is frame-based, using a one-cycle `frame_tick` from the VGA timing logic.

## Interface
- `LIVES`, default 3: lives per game; legal range 1..3.
- `DEAD_FRAMES`, default 30: frames spent in the death pause before respawn; legal range 1..255.
- `LEVEL_FRAMES`, default 1800: per-level time budget in frames (used only with `GAME_TIMER_EN`); legal range 1..2047.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: start/restart request, level-sensitive, sampled each cycle.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `crushed` in 1: comparator collision flag; sticky until the comparator is reset.
- `level_up` in 1: comparator level-2 flag; sticky.
- `endgame` in 1: comparator win flag; sticky.
- `cmp_resetn` out 1: active-low reset to the comparator.
- `respawn` out 1: one-cycle pulse that returns the human and vehicles to their start positions.
- `playing` out 1: high in PLAY.
- `game_over` out 1: high in OVER.
- `game_won` out 1: high in WIN.
- `lives` out 2: remaining lives.
- `level` out 1: 0 for level 1, 1 for level 2.
- `timer_left` out 11: frames remaining in the current level.

## Operation
- All outputs are registered.
- States:
  - IDLE: `cmp_resetn`=0.
  - CLEAR: single cycle; `cmp_resetn`=0, `respawn`=1.
  - PLAY: `cmp_resetn`=1, `playing`=1.
  - DYING: `cmp_resetn`=1; the still-high `crushed` is ignored.
  - OVER: `cmp_resetn`=0, `game_over`=1.
  - WIN: `cmp_resetn`=0, `game_won`=1.
- Transitions:
  - IDLE, OVER, WIN: `start`=1 → CLEAR; `lives`←`LIVES`, `level`←0.
  - CLEAR → PLAY, unconditionally. Also clears the `level_up` edge register `lu_q`.
  - PLAY, in priority order:
    1. `crushed` (or timer expiry): if `lives`==1 → OVER with `lives`←0; else `lives`←`lives`−1, load `dead_cnt`←`DEAD_FRAMES`, → DYING.
    2. `endgame` → WIN.
    3. `level_up`=1 with `lu_q`=0 → `level`←1.
  - DYING: each `frame_tick` decrements `dead_cnt`. A tick that takes `dead_cnt` from 1 to 0 → CLEAR with `level`←0, because a death returns the player to level 1 (the comparator drops `level_up` on its reset).
- `start` is ignored in CLEAR, PLAY and DYING.
- `frame_tick` is ignored outside PLAY and DYING.
- `lu_q` samples `level_up` every PLAY cycle.

## Timing
- Reset values: state IDLE, `cmp_resetn`=0, `respawn`=0, `playing`=0, `game_over`=0, `game_won`=0, `lives`=`LIVES`, `level`=0, `timer_left`=0.
- A flag sampled high at edge N in PLAY produces the new state/outputs after edge N; outputs reflect it in cycle N+1.
- `cmp_resetn` is low for exactly one cycle (the CLEAR cycle) on every respawn. `respawn` and the low `cmp_resetn` are coincident.
- From entering DYING to entering CLEAR takes exactly `DEAD_FRAMES` `frame_tick` pulses.
- Simultaneous events:
  - `crushed` and `endgame` in the same cycle: crushed wins.
  - `crushed` and timer expiry in the same cycle: only one life is lost.
  - `crushed` and a `level_up` edge in the same cycle: the level does not change.
- `reset` asserted mid-game: immediate return to the reset values, regardless of state.

## Configuration
- Macro: `GAME_TIMER_EN`.
- Defined:
  - `timer_left` loads `LEVEL_FRAMES` in CLEAR and again on the accepted `level_up` edge.
  - It decrements on each `frame_tick` in PLAY.
  - A tick taking it from 1 to 0 is treated exactly as `crushed`.
  - It holds its value in DYING, OVER and WIN.
- Undefined: `timer_left` is tied to 0 and no timeout ever occurs.

## Test plan
- Reset, then `start`=1 for one cycle: next cycle is CLEAR with `respawn`=1 and `cmp_resetn`=0; the cycle after has `playing`=1, `cmp_resetn`=1, `lives`=3.
- In PLAY, `crushed`=1: `lives`=2, state DYING. After exactly 30 `frame_tick` pulses: one-cycle `respawn`, `level`=0, `playing`=1.
- Three crushes: after the third, `game_over`=1, `lives`=0, `cmp_resetn`=0; a later `start` gives `lives`=3 and a CLEAR pulse.
- `level_up` rises and stays high: `level`=1 the next cycle. Then `endgame`=1 with `crushed`=1 in the same cycle: DYING, not WIN, and `level` is 0 after respawn.
- `GAME_TIMER_EN` with `LEVEL_FRAMES`=5: after 5 `frame_tick` pulses in PLAY with no other events, `lives`=`LIVES`−1 and the state is DYING.
- Assert `reset` during DYING: the same cycle shows IDLE values (`cmp_resetn`=0, `lives`=3, `respawn`=0).
